regfile_write_arbiter: RTL and testbench

// - Shares the single write port (ADDR_IN/D_IN/WE) of a multi-read-port register file among NUM_REQ writers.
// - Uses round-robin valid/ready arbitration.
// - Contains a clear engine that sweeps LO..HI with a fill value; the sweep has priority over client writes.
// - Sits between pipeline writeback/CSR/debug writers and the register file; read ports are untouched.

---
 rtl/regfile_write_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for a register-file write port with a priority clear sweep
module regfile_write_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4,
    parameter int LO         = 0,
    parameter int HI         = 31
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          clr_start,
    input  logic [DATA_WIDTH-1:0]         clr_value,
    output logic                          clr_busy,
    output logic                          clr_done,
    output logic                          addr_err,
    output logic [ADDR_WIDTH-1:0]         rf_addr,
    output logic [DATA_WIDTH-1:0]         rf_data,
    output logic                          rf_we
);
    localparam int                    PTR_W    = $clog2(NUM_REQ);
    localparam logic [ADDR_WIDTH-1:0] LO_A     = ADDR_WIDTH'(LO);
    localparam logic [ADDR_WIDTH-1:0] HI_A     = ADDR_WIDTH'(HI);
    localparam logic [PTR_W-1:0]      LAST_REQ = PTR_W'(NUM_REQ - 1);

    typedef enum logic {ST_ARB, ST_CLEAR} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      w_grant_idx;
    logic [PTR_W-1:0]      w_scan;
    int                    w_sum;
    logic                  w_found;
    logic                  w_arb_ok;
    logic                  w_xfer;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [ADDR_WIDTH-1:0] r_rf_addr;
    logic [DATA_WIDTH-1:0] r_clr_val;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [DATA_WIDTH-1:0] r_rf_data;
    logic                  r_rf_we;
    logic                  r_clr_done;
    logic                  r_addr_err;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_sum       = 0;
        w_scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
            w_scan = PTR_W'(w_sum);
            if (!w_found && req_valid[w_scan]) begin
                w_found     = 1'b1;
                w_grant_idx = w_scan;
            end
        end
    end

    assign w_arb_ok = RST_N && (r_state == ST_ARB) && !clr_start;

    always_comb begin
        req_ready  = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == PTR_W'(i)) begin
                req_ready[i] = w_arb_ok && w_found;
                w_sel_addr   = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_xfer     = |req_ready;
    assign w_in_range = !((int'(w_sel_addr) < LO) || (int'(w_sel_addr) > HI));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_ARB:   if (clr_start) w_next_state = ST_CLEAR;
            ST_CLEAR: if (r_cnt == HI_A) w_next_state = ST_ARB;
            default:  w_next_state = ST_ARB;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= ST_ARB;
            r_rr_ptr   <= '0;
            r_cnt      <= LO_A;
            r_clr_val  <= '0;
            r_rf_we    <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_data  <= '0;
            r_clr_done <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_rf_we    <= 1'b0;
            r_clr_done <= 1'b0;
            r_addr_err <= 1'b0;
            if (r_state == ST_ARB) begin
                if (clr_start) begin
                    r_clr_val <= clr_value;
                    r_cnt     <= LO_A;
                end else if (w_xfer) begin
                    r_rr_ptr <= (w_grant_idx == LAST_REQ) ? '0 : w_grant_idx + PTR_W'(1);
                    // Out-of-range writes are consumed but never reach the array.
                    if (w_in_range) begin
                        r_rf_we   <= 1'b1;
                        r_rf_addr <= w_sel_addr;
                        r_rf_data <= w_sel_data;
                    end else begin
                        r_addr_err <= 1'b1;
                    end
                end
            end else begin
                r_rf_we   <= 1'b1;
                r_rf_addr <= r_cnt;
                r_rf_data <= r_clr_val;
                if (r_cnt == HI_A) r_clr_done <= 1'b1;
                else               r_cnt      <= r_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    assign clr_busy = (r_state == ST_CLEAR);
    assign clr_done = r_clr_done;
    assign addr_err = r_addr_err;
    assign rf_addr  = r_rf_addr;
    assign rf_data  = r_rf_data;
    assign rf_we    = r_rf_we;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 4;

    logic           CLK;
    logic           RST_N;
    logic [NR-1:0]  req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic           clr_start;
    logic [DW-1:0]  clr_value;

    logic [NR-1:0]  req_ready;
    logic           clr_busy, clr_done, addr_err, rf_we;
    logic [AW-1:0]  rf_addr;
    logic [DW-1:0]  rf_data;

    logic [NR-1:0]  rng_ready;
    logic           rng_busy, rng_done, rng_err, rng_we;
    logic [AW-1:0]  rng_addr;
    logic [DW-1:0]  rng_data;

    int checks   = 0;
    int failures = 0;

    regfile_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .LO(0), .HI(31)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(clr_busy), .clr_done(clr_done), .addr_err(addr_err),
        .rf_addr(rf_addr), .rf_data(rf_data), .rf_we(rf_we)
    );

    regfile_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .LO(4), .HI(27)) u_dut_rng (
        .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(rng_ready),
        .req_addr(req_addr), .req_data(req_data), .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(rng_busy), .clr_done(rng_done), .addr_err(rng_err),
        .rf_addr(rng_addr), .rf_data(rng_data), .rf_we(rng_we)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_client(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        RST_N     = 1'b0;
        req_valid = '0;
        clr_start = 1'b0;
        clr_value = '0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N     = 1'b0;
        req_valid = 4'hF;
        clr_start = 1'b0;
        clr_value = '0;
        for (int i = 0; i < NR; i++) set_client(i, AW'(i), DW'(i));
        for (int c = 0; c < 3; c++) begin
            tick();
            @(negedge CLK);
            checks++;
            if ({req_ready, rf_we, clr_busy, clr_done, addr_err, rf_addr, rf_data} !== '0) begin
                failures++;
                $display("FAIL reset_outputs c=%0d ready=%b we=%b busy=%b done=%b err=%b addr=%h data=%h expected all zero",
                         c, req_ready, rf_we, clr_busy, clr_done, addr_err, rf_addr, rf_data);
            end
        end
        tick();
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_grant ready=%b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge CLK);
        checks++;
        if ({rf_we, rf_addr} !== {1'b1, 5'd0}) begin
            failures++;
            $display("FAIL reset_first_write we=%b addr=%0d expected we=1 addr=0", rf_we, rf_addr);
        end
    endtask

    task automatic test_fairness();
        logic [NR-1:0]     exp_ready;
        logic [AW+DW:0]    exp_wr;
        do_reset();
        req_valid = 4'hF;
        for (int i = 0; i < NR; i++) set_client(i, AW'(i), DW'(64'hA0 + i));
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            exp_ready = 4'b0001 << (k % 4);
            checks++;
            if (req_ready !== exp_ready) begin
                failures++;
                $display("FAIL fair_grant k=%0d ready=%b expected %b", k, req_ready, exp_ready);
            end
            if (k > 0) begin
                exp_wr = {1'b1, AW'((k - 1) % 4), DW'(64'hA0 + (k - 1) % 4)};
                checks++;
                if ({rf_we, rf_addr, rf_data} !== exp_wr) begin
                    failures++;
                    $display("FAIL fair_write k=%0d we=%b addr=%0d data=%h expected %h", k, rf_we, rf_addr, rf_data, exp_wr);
                end
            end
            tick();
        end
        req_valid = '0;
        @(negedge CLK);
        checks++;
        if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd3, 64'hA3}) begin
            failures++;
            $display("FAIL fair_last_write we=%b addr=%0d data=%h expected 1/3/a3", rf_we, rf_addr, rf_data);
        end
        tick();
        @(negedge CLK);
        checks++;
        if ({rf_we, rf_addr, rf_data} !== {1'b0, 5'd3, 64'hA3}) begin
            failures++;
            $display("FAIL fair_idle_hold we=%b addr=%0d data=%h expected 0/3/a3", rf_we, rf_addr, rf_data);
        end
    endtask

    task automatic test_skip();
        logic [NR-1:0] exp_seq [3];
        exp_seq[0] = 4'b0010;
        exp_seq[1] = 4'b1000;
        exp_seq[2] = 4'b0010;
        do_reset();
        req_valid = 4'b1010;
        for (int i = 0; i < NR; i++) set_client(i, AW'(i + 16), DW'(i));
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            checks++;
            if (req_ready !== exp_seq[k]) begin
                failures++;
                $display("FAIL skip_grant k=%0d ready=%b expected %b", k, req_ready, exp_seq[k]);
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_clear();
        logic [AW+DW:0] exp_wr;
        do_reset();
        req_valid = 4'b0100;
        set_client(2, 5'd5, 64'h55);
        clr_start = 1'b1;
        clr_value = 64'hDEAD;
        @(negedge CLK);
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL clear_start_blocks ready=%b expected 0000", req_ready);
        end
        tick();
        clr_start = 1'b0;
        clr_value = 64'h0;
        @(negedge CLK);
        checks++;
        if ({clr_busy, rf_we, req_ready} !== {1'b1, 1'b0, 4'b0000}) begin
            failures++;
            $display("FAIL clear_t1 busy=%b we=%b ready=%b expected 1/0/0000", clr_busy, rf_we, req_ready);
        end
        tick();
        for (int k = 0; k < 32; k++) begin
            clr_start = (k == 8);
            @(negedge CLK);
            exp_wr = {1'b1, AW'(k), 64'hDEAD};
            checks++;
            if ({rf_we, rf_addr, rf_data} !== exp_wr) begin
                failures++;
                $display("FAIL clear_write k=%0d we=%b addr=%0d data=%h expected %h", k, rf_we, rf_addr, rf_data, exp_wr);
            end
            checks++;
            if ({clr_done, clr_busy} !== {(k == 31), (k != 31)}) begin
                failures++;
                $display("FAIL clear_flags k=%0d done=%b busy=%b expected %b/%b", k, clr_done, clr_busy, (k == 31), (k != 31));
            end
            checks++;
            if (req_ready !== ((k == 31) ? 4'b0100 : 4'b0000)) begin
                failures++;
                $display("FAIL clear_ready k=%0d ready=%b expected %b", k, req_ready, (k == 31) ? 4'b0100 : 4'b0000);
            end
            tick();
        end
        clr_start = 1'b0;
        req_valid = '0;
        @(negedge CLK);
        checks++;
        if ({rf_we, rf_addr, rf_data, clr_done, clr_busy} !== {1'b1, 5'd5, 64'h55, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL clear_after we=%b addr=%0d data=%h done=%b busy=%b expected 1/5/55/0/0",
                     rf_we, rf_addr, rf_data, clr_done, clr_busy);
        end
    endtask

    task automatic test_range();
        do_reset();
        req_valid = 4'b0010;
        set_client(1, 5'd30, 64'h99);
        @(negedge CLK);
        checks++;
        if ({rng_ready, req_ready} !== {4'b0010, 4'b0010}) begin
            failures++;
            $display("FAIL range_accept rng_ready=%b ready=%b expected 0010/0010", rng_ready, req_ready);
        end
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) set_client(i, AW'(8 + i), DW'(64'hB0 + i));
        @(negedge CLK);
        checks++;
        if ({rng_we, rng_err} !== 2'b01) begin
            failures++;
            $display("FAIL range_drop we=%b err=%b expected we=0 err=1", rng_we, rng_err);
        end
        checks++;
        if (rng_ready !== 4'b0100) begin
            failures++;
            $display("FAIL range_ptr_adv ready=%b expected 0100", rng_ready);
        end
        checks++;
        if ({rf_we, rf_addr, addr_err} !== {1'b1, 5'd30, 1'b0}) begin
            failures++;
            $display("FAIL range_full_ok we=%b addr=%0d err=%b expected 1/30/0", rf_we, rf_addr, addr_err);
        end
        tick();
        req_valid = 4'b1000;
        set_client(3, 5'd2, 64'hC3);
        @(negedge CLK);
        checks++;
        if ({rng_we, rng_err, rng_addr, rng_data} !== {1'b1, 1'b0, 5'd10, 64'hB2}) begin
            failures++;
            $display("FAIL range_inside we=%b err=%b addr=%0d data=%h expected 1/0/10/b2", rng_we, rng_err, rng_addr, rng_data);
        end
        tick();
        req_valid = 4'b0011;
        set_client(0, 5'd27, 64'hE0);
        set_client(1, 5'd4, 64'hE1);
        @(negedge CLK);
        checks++;
        if ({rng_we, rng_err, rng_ready} !== {1'b0, 1'b1, 4'b0001}) begin
            failures++;
            $display("FAIL range_below we=%b err=%b ready=%b expected 0/1/0001", rng_we, rng_err, rng_ready);
        end
        tick();
        req_valid = 4'b0010;
        @(negedge CLK);
        checks++;
        if ({rng_we, rng_err, rng_addr} !== {1'b1, 1'b0, 5'd27}) begin
            failures++;
            $display("FAIL range_hi_edge we=%b err=%b addr=%0d expected 1/0/27", rng_we, rng_err, rng_addr);
        end
        tick();
        req_valid = '0;
        @(negedge CLK);
        checks++;
        if ({rng_we, rng_err, rng_addr, rng_data} !== {1'b1, 1'b0, 5'd4, 64'hE1}) begin
            failures++;
            $display("FAIL range_lo_edge we=%b err=%b addr=%0d data=%h expected 1/0/4/e1", rng_we, rng_err, rng_addr, rng_data);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic seen;
        do_reset();
        clr_start = 1'b1;
        clr_value = 64'h1234;
        tick();
        clr_start = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) tick();
        @(negedge CLK);
        checks++;
        if ({rf_we, rf_addr, clr_busy} !== {1'b1, 5'd10, 1'b1}) begin
            failures++;
            $display("FAIL midclr_pos we=%b addr=%0d busy=%b expected 1/10/1", rf_we, rf_addr, clr_busy);
        end
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if ({clr_busy, rf_we, clr_done} !== 3'b000) begin
            failures++;
            $display("FAIL midclr_abort busy=%b we=%b done=%b expected 000", clr_busy, rf_we, clr_done);
        end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            @(negedge CLK);
            if (clr_done || rf_we || clr_busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midclr_quiet activity=%b expected 0", seen);
        end
        tick();
        clr_start = 1'b1;
        clr_value = 64'h77;
        tick();
        clr_start = 1'b0;
        tick();
        @(negedge CLK);
        checks++;
        if ({rf_we, rf_addr, rf_data, clr_busy} !== {1'b1, 5'd0, 64'h77, 1'b1}) begin
            failures++;
            $display("FAIL midclr_restart we=%b addr=%0d data=%h busy=%b expected 1/0/77/1", rf_we, rf_addr, rf_data, clr_busy);
        end
    endtask

    initial begin
        req_addr = '0;
        req_data = '0;
        test_reset();
        test_fairness();
        test_skip();
        test_clear();
        test_range();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
